// File: rtl/ie_stage_if.sv
// ID/IE -> IE -> IE/MEM signal bundle for the execute stage.
// The master side drives the ID/IE latch outputs and hazard controls and
// observes the stage results; the slave side is the execute stage itself.
// There is no valid/ready handshake here: every cycle the stage consumes
// whatever the ID/IE latch presents, and only stall/flush qualify the
// update of the IE/MEM latch.
interface ie_stage_if;
    // Operands and control from the ID/IE latch
    logic [15:0] RsrcData;
    logic [15:0] RdstData;
    logic [15:0] immValue;
    logic [2:0]  RdstAddress;
    logic [3:0]  AluOp;
    logic        WB;
    logic        memRead;
    logic        memWrite;
    logic        writeFlag;
    logic        branch;
    logic        JZ;
    logic        JC;
    logic        JN;
    // Forwarding selects and write-back forwarding value
    logic [1:0]  fwdSrcSel;
    logic [1:0]  fwdDstSel;
    logic [15:0] memWbData;
    // Hazard controls
    logic        stall;
    logic        flush;
    // Branch resolution (combinational)
    logic        branchTaken;
    logic [15:0] branchTarget;
    // Flag register and IE/MEM latch (registered)
    logic [2:0]  flags;
    logic [15:0] outAluResult;
    logic [15:0] outMemData;
    logic [2:0]  outRdstAddress;
    logic        outWB;
    logic        outMemRead;
    logic        outMemWrite;

    modport master (
        output RsrcData, RdstData, immValue, RdstAddress, AluOp,
        output WB, memRead, memWrite, writeFlag,
        output branch, JZ, JC, JN,
        output fwdSrcSel, fwdDstSel, memWbData,
        output stall, flush,
        input  branchTaken, branchTarget, flags,
        input  outAluResult, outMemData, outRdstAddress,
        input  outWB, outMemRead, outMemWrite
    );

    modport slave (
        input  RsrcData, RdstData, immValue, RdstAddress, AluOp,
        input  WB, memRead, memWrite, writeFlag,
        input  branch, JZ, JC, JN,
        input  fwdSrcSel, fwdDstSel, memWbData,
        input  stall, flush,
        output branchTaken, branchTarget, flags,
        output outAluResult, outMemData, outRdstAddress,
        output outWB, outMemRead, outMemWrite
    );
endinterface

// File: rtl/ie_stage.sv
// Execute stage: operand forwarding, 16-bit ALU, {N,C,Z} flag register,
// branch resolution and the IE/MEM pipeline latch.
module ie_stage (
    input  logic          clk,
    input  logic          rst,
    ie_stage_if.slave     bus
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_MOV  = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_NOT  = 4'd6,
        OP_INC  = 4'd7,
        OP_DEC  = 4'd8,
        OP_SHL  = 4'd9,
        OP_SHR  = 4'd10,
        OP_SETC = 4'd11,
        OP_CLRC = 4'd12,
        OP_LDM  = 4'd13,
        OP_IADD = 4'd14,
        OP_RSVD = 4'd15
    } alu_op_e;

    // Forwarding select encodings
    localparam logic [1:0] FWD_LATCH = 2'd0;
    localparam logic [1:0] FWD_EXMEM = 2'd1;
    localparam logic [1:0] FWD_MEMWB = 2'd2;

    // Flag bit positions inside {N,C,Z}
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;

    alu_op_e     alu_op;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [3:0]  sh_amt;

    // Wide intermediates so carries fall out of bit 16
    logic [16:0] add_w;
    logic [16:0] inc_w;
    logic [16:0] iadd_w;
    logic [16:0] shl_w;
    logic [16:0] shr_w;

    logic [15:0] alu_res;
    logic        upd_zn;
    logic        upd_c;
    logic        c_val;

    logic [2:0]  flags_q;
    logic [2:0]  flags_d;
    logic [2:0]  flags_alu;
    logic [2:0]  flags_clr;
    logic        branch_taken;

    logic [15:0] alu_result_q, alu_result_d;
    logic [15:0] mem_data_q,   mem_data_d;
    logic [2:0]  rdst_addr_q,  rdst_addr_d;
    logic        wb_q,         wb_d;
    logic        mem_read_q,   mem_read_d;
    logic        mem_write_q,  mem_write_d;

    assign alu_op = alu_op_e'(bus.AluOp);
    assign sh_amt = bus.immValue[3:0];

    // Operand A (Rdst) forwarding mux; sel 1 uses our own registered result
    always_comb begin
        case (bus.fwdDstSel)
            FWD_LATCH: op_a = bus.RdstData;
            FWD_EXMEM: op_a = alu_result_q;
            FWD_MEMWB: op_a = bus.memWbData;
            default:   op_a = 16'h0000;
        endcase
    end

    // Operand B (Rsrc) forwarding mux; also the store data for MEM
    always_comb begin
        case (bus.fwdSrcSel)
            FWD_LATCH: op_b = bus.RsrcData;
            FWD_EXMEM: op_b = alu_result_q;
            FWD_MEMWB: op_b = bus.memWbData;
            default:   op_b = 16'h0000;
        endcase
    end

    // Shift carries: the bit shifted out last lands at bit 16 (SHL) or bit 0 (SHR)
    assign add_w  = {1'b0, op_a} + {1'b0, op_b};
    assign inc_w  = {1'b0, op_a} + 17'd1;
    assign iadd_w = {1'b0, op_a} + {1'b0, bus.immValue};
    assign shl_w  = {1'b0, op_a} << sh_amt;
    assign shr_w  = {op_a, 1'b0} >> sh_amt;

    // ALU result and which flags this op is allowed to write
    always_comb begin
        alu_res = op_a;
        upd_zn  = 1'b0;
        upd_c   = 1'b0;
        c_val   = 1'b0;
        case (alu_op)
            OP_NOP: alu_res = op_a;
            OP_MOV: alu_res = op_b;
            OP_ADD: begin
                alu_res = add_w[15:0];
                upd_zn  = 1'b1;
                upd_c   = 1'b1;
                c_val   = add_w[16];
            end
            OP_SUB: begin
                alu_res = op_a - op_b;
                upd_zn  = 1'b1;
                upd_c   = 1'b1;
                c_val   = (op_a < op_b);
            end
            OP_AND: begin
                alu_res = op_a & op_b;
                upd_zn  = 1'b1;
            end
            OP_OR: begin
                alu_res = op_a | op_b;
                upd_zn  = 1'b1;
            end
            OP_NOT: begin
                alu_res = ~op_a;
                upd_zn  = 1'b1;
            end
            OP_INC: begin
                alu_res = inc_w[15:0];
                upd_zn  = 1'b1;
                upd_c   = 1'b1;
                c_val   = inc_w[16];
            end
            OP_DEC: begin
                alu_res = op_a - 16'd1;
                upd_zn  = 1'b1;
                upd_c   = 1'b1;
                c_val   = (op_a == 16'h0000);
            end
            OP_SHL: begin
                alu_res = shl_w[15:0];
                upd_zn  = 1'b1;
                // A zero shift amount leaves carry untouched
                upd_c   = (sh_amt != 4'd0);
                c_val   = shl_w[16];
            end
            OP_SHR: begin
                alu_res = shr_w[16:1];
                upd_zn  = 1'b1;
                upd_c   = (sh_amt != 4'd0);
                c_val   = shr_w[0];
            end
            OP_SETC: begin
                alu_res = op_a;
                upd_c   = 1'b1;
                c_val   = 1'b1;
            end
            OP_CLRC: begin
                alu_res = op_a;
                upd_c   = 1'b1;
                c_val   = 1'b0;
            end
            OP_LDM:  alu_res = bus.immValue;
            OP_IADD: begin
                alu_res = iadd_w[15:0];
                upd_zn  = 1'b1;
                upd_c   = 1'b1;
                c_val   = iadd_w[16];
            end
            OP_RSVD: alu_res = 16'h0000;
            default: alu_res = 16'h0000;
        endcase
    end

    // Branch decision looks at the flags as registered at the start of the cycle
    always_comb begin
        flags_clr[FLAG_Z] = bus.JZ & flags_q[FLAG_Z];
        flags_clr[FLAG_C] = bus.JC & flags_q[FLAG_C];
        flags_clr[FLAG_N] = bus.JN & flags_q[FLAG_N];
        branch_taken      = bus.branch | (|flags_clr);
    end

    // Next flags: ALU write (if enabled), then a taken conditional jump clears its flag
    always_comb begin
        flags_alu = flags_q;
        if (bus.writeFlag) begin
            if (upd_zn) begin
                flags_alu[FLAG_Z] = (alu_res == 16'h0000);
                flags_alu[FLAG_N] = alu_res[15];
            end
            if (upd_c) begin
                flags_alu[FLAG_C] = c_val;
            end
        end
        flags_d = flags_alu & ~flags_clr;
    end

    // Flag register: flush does not block it (the flushed op is the younger one)
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 3'b000;
        end else if (!bus.stall) begin
            flags_q <= flags_d;
        end
    end

    // IE/MEM latch next-state values
    always_comb begin
        alu_result_d = alu_res;
        mem_data_d   = op_b;
        rdst_addr_d  = bus.RdstAddress;
        wb_d         = bus.WB;
        mem_read_d   = bus.memRead;
        mem_write_d  = bus.memWrite;
    end

    // IE/MEM latch with priority rst > flush > stall > load
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            alu_result_q <= 16'h0000;
            mem_data_q   <= 16'h0000;
            rdst_addr_q  <= 3'b000;
            wb_q         <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
        end else if (!bus.stall) begin
            alu_result_q <= alu_result_d;
            mem_data_q   <= mem_data_d;
            rdst_addr_q  <= rdst_addr_d;
            wb_q         <= wb_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
        end
    end

    assign bus.branchTaken    = branch_taken;
    assign bus.branchTarget   = op_a;
    assign bus.flags          = flags_q;
    assign bus.outAluResult   = alu_result_q;
    assign bus.outMemData     = mem_data_q;
    assign bus.outRdstAddress = rdst_addr_q;
    assign bus.outWB          = wb_q;
    assign bus.outMemRead     = mem_read_q;
    assign bus.outMemWrite    = mem_write_q;

endmodule

// File: tb/tb_ie_stage.sv
// Directed bench for ie_stage: hand-computed expectations, immediate asserts.
module tb_ie_stage;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    ie_stage_if bus ();

    ie_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled on the falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Return all stage inputs to a neutral value
    task automatic idle();
        bus.RsrcData    = 16'h0000;
        bus.RdstData    = 16'h0000;
        bus.immValue    = 16'h0000;
        bus.RdstAddress = 3'd0;
        bus.AluOp       = 4'd0;
        bus.WB          = 1'b0;
        bus.memRead     = 1'b0;
        bus.memWrite    = 1'b0;
        bus.writeFlag   = 1'b0;
        bus.branch      = 1'b0;
        bus.JZ          = 1'b0;
        bus.JC          = 1'b0;
        bus.JN          = 1'b0;
        bus.fwdSrcSel   = 2'd0;
        bus.fwdDstSel   = 2'd0;
        bus.memWbData   = 16'h0000;
        bus.stall       = 1'b0;
        bus.flush       = 1'b0;
    endtask

    task automatic op(input logic [3:0] code, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] imm, input logic wf);
        idle();
        bus.AluOp     = code;
        bus.RdstData  = a;
        bus.RsrcData  = b;
        bus.immValue  = imm;
        bus.writeFlag = wf;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        idle();
        bus.RdstData = 16'h00AB;

        // Reset held for two cycles
        tick();
        tick();
        chk("rst_result",  bus.outAluResult, 16'h0000);
        chk("rst_memdata", bus.outMemData, 16'h0000);
        chk("rst_addr",    {13'd0, bus.outRdstAddress}, 16'h0000);
        chk("rst_ctl",     {13'd0, bus.outWB, bus.outMemRead, bus.outMemWrite}, 16'h0000);
        chk("rst_flags",   {13'd0, bus.flags}, 16'h0000);
        chk("rst_taken",   {15'd0, bus.branchTaken}, 16'h0000);
        chk("rst_target",  bus.branchTarget, 16'h00AB);
        rst = 1'b0;

        // ADD 3+4 with controls carried forward
        op(4'd2, 16'h0003, 16'h0004, 16'h0000, 1'b1);
        bus.WB = 1'b1; bus.memRead = 1'b1; bus.RdstAddress = 3'd5;
        tick();
        chk("add_result",  bus.outAluResult, 16'h0007);
        chk("add_flags",   {13'd0, bus.flags}, 16'h0000);
        chk("add_memdata", bus.outMemData, 16'h0004);
        chk("add_addr",    {13'd0, bus.outRdstAddress}, 16'h0005);
        chk("add_ctl",     {13'd0, bus.outWB, bus.outMemRead, bus.outMemWrite}, 16'h0006);

        // ADD wrap: Z=1, C=1
        op(4'd2, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
        tick();
        chk("addc_result", bus.outAluResult, 16'h0000);
        chk("addc_flags",  {13'd0, bus.flags}, 16'h0003);

        // JZ with Z=1: taken, Z cleared
        op(4'd0, 16'h0040, 16'h0000, 16'h0000, 1'b0);
        bus.JZ = 1'b1;
        #1;
        chk("jz_taken",  {15'd0, bus.branchTaken}, 16'h0001);
        chk("jz_target", bus.branchTarget, 16'h0040);
        tick();
        chk("jz_flags",  {13'd0, bus.flags}, 16'h0002);
        chk("jz_result", bus.outAluResult, 16'h0040);

        // JZ with Z=0: not taken
        op(4'd0, 16'h0041, 16'h0000, 16'h0000, 1'b0);
        bus.JZ = 1'b1;
        #1;
        chk("jz0_taken", {15'd0, bus.branchTaken}, 16'h0000);
        tick();
        chk("jz0_flags", {13'd0, bus.flags}, 16'h0002);

        // Unconditional branch: taken, flags untouched
        op(4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        bus.branch = 1'b1;
        #1;
        chk("br_taken", {15'd0, bus.branchTaken}, 16'h0001);
        tick();
        chk("br_flags", {13'd0, bus.flags}, 16'h0002);

        // SUB 2-5: borrow and negative
        op(4'd3, 16'h0002, 16'h0005, 16'h0000, 1'b1);
        tick();
        chk("sub_result", bus.outAluResult, 16'hFFFD);
        chk("sub_flags",  {13'd0, bus.flags}, 16'h0006);

        // JN taken while SUB writes N: clear wins
        op(4'd3, 16'h0002, 16'h0005, 16'h0000, 1'b1);
        bus.JN = 1'b1;
        #1;
        chk("jn_taken", {15'd0, bus.branchTaken}, 16'h0001);
        tick();
        chk("jn_result", bus.outAluResult, 16'hFFFD);
        chk("jn_flags",  {13'd0, bus.flags}, 16'h0002);

        // CLRC
        op(4'd12, 16'h1111, 16'h0000, 16'h0000, 1'b1);
        tick();
        chk("clrc_result", bus.outAluResult, 16'h1111);
        chk("clrc_flags",  {13'd0, bus.flags}, 16'h0000);

        // SHL 0x8001 by 1: carry out of bit 15
        op(4'd9, 16'h8001, 16'h0000, 16'h0001, 1'b1);
        tick();
        chk("shl_result", bus.outAluResult, 16'h0002);
        chk("shl_flags",  {13'd0, bus.flags}, 16'h0002);

        // SHR by 0: C unchanged
        op(4'd10, 16'h0003, 16'h0000, 16'h0000, 1'b1);
        tick();
        chk("shr0_result", bus.outAluResult, 16'h0003);
        chk("shr0_flags",  {13'd0, bus.flags}, 16'h0002);

        // SHR 0x0002 by 1: C = A[0] = 0
        op(4'd10, 16'h0002, 16'h0000, 16'h0001, 1'b1);
        tick();
        chk("shr1_result", bus.outAluResult, 16'h0001);
        chk("shr1_flags",  {13'd0, bus.flags}, 16'h0000);

        // Back-to-back dependency through IE/MEM forwarding
        op(4'd2, 16'h0008, 16'h0008, 16'h0000, 1'b0);
        tick();
        chk("fwd_add", bus.outAluResult, 16'h0010);
        op(4'd7, 16'hDEAD, 16'h0000, 16'h0000, 1'b0);
        bus.fwdDstSel = 2'd1;
        #1;
        chk("fwd_target", bus.branchTarget, 16'h0010);
        tick();
        chk("fwd_inc", bus.outAluResult, 16'h0011);

        // Forward memWbData into Rsrc with MOV
        op(4'd1, 16'h0000, 16'h5555, 16'h0000, 1'b0);
        bus.fwdSrcSel = 2'd2;
        bus.memWbData = 16'h1234;
        tick();
        chk("mov_result",  bus.outAluResult, 16'h1234);
        chk("mov_memdata", bus.outMemData, 16'h1234);

        // LDM writes no flags even with writeFlag
        op(4'd13, 16'h0007, 16'h0007, 16'hBEEF, 1'b1);
        tick();
        chk("ldm_result", bus.outAluResult, 16'hBEEF);
        chk("ldm_flags",  {13'd0, bus.flags}, 16'h0000);

        // IADD with carry
        op(4'd14, 16'hFFF0, 16'h0000, 16'h0020, 1'b1);
        tick();
        chk("iadd_result", bus.outAluResult, 16'h0010);
        chk("iadd_flags",  {13'd0, bus.flags}, 16'h0002);

        // DEC of zero
        op(4'd8, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        tick();
        chk("dec_result", bus.outAluResult, 16'hFFFF);
        chk("dec_flags",  {13'd0, bus.flags}, 16'h0006);

        // NOT to zero: Z=1, C kept
        op(4'd6, 16'hFFFF, 16'h0000, 16'h0000, 1'b1);
        tick();
        chk("not_result", bus.outAluResult, 16'h0000);
        chk("not_flags",  {13'd0, bus.flags}, 16'h0003);

        // Zero select on both operands
        op(4'd5, 16'h1234, 16'h5678, 16'h0000, 1'b1);
        bus.fwdDstSel = 2'd3;
        bus.fwdSrcSel = 2'd3;
        #1;
        chk("zsel_target", bus.branchTarget, 16'h0000);
        tick();
        chk("zsel_result", bus.outAluResult, 16'h0000);
        chk("zsel_flags",  {13'd0, bus.flags}, 16'h0003);

        // Stall two cycles with a taken JZ pending: everything frozen
        op(4'd2, 16'h0001, 16'h0001, 16'h0000, 1'b1);
        bus.WB = 1'b1; bus.JZ = 1'b1; bus.stall = 1'b1;
        #1;
        chk("stall_taken", {15'd0, bus.branchTaken}, 16'h0001);
        tick();
        chk("stall1_result", bus.outAluResult, 16'h0000);
        chk("stall1_wb",     {15'd0, bus.outWB}, 16'h0000);
        chk("stall1_flags",  {13'd0, bus.flags}, 16'h0003);
        tick();
        chk("stall2_result", bus.outAluResult, 16'h0000);
        chk("stall2_flags",  {13'd0, bus.flags}, 16'h0003);

        // Flush: bubble in the latch, flags still written
        op(4'd3, 16'h0002, 16'h0005, 16'h0000, 1'b1);
        bus.flush = 1'b1; bus.memWrite = 1'b1; bus.WB = 1'b1;
        tick();
        chk("flush_result", bus.outAluResult, 16'h0000);
        chk("flush_ctl",    {13'd0, bus.outWB, bus.outMemRead, bus.outMemWrite}, 16'h0000);
        chk("flush_flags",  {13'd0, bus.flags}, 16'h0006);

        // OR
        op(4'd5, 16'h8000, 16'h0001, 16'h0000, 1'b1);
        tick();
        chk("or_result", bus.outAluResult, 16'h8001);
        chk("or_flags",  {13'd0, bus.flags}, 16'h0006);

        // Reserved op: zero result, no flags
        op(4'd15, 16'h0005, 16'h0005, 16'h0000, 1'b1);
        tick();
        chk("rsvd_result", bus.outAluResult, 16'h0000);
        chk("rsvd_flags",  {13'd0, bus.flags}, 16'h0006);

        // JC with C=1: taken, only C cleared
        op(4'd0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        bus.JC = 1'b1;
        #1;
        chk("jc_taken", {15'd0, bus.branchTaken}, 16'h0001);
        tick();
        chk("jc_flags", {13'd0, bus.flags}, 16'h0004);

        // AND
        op(4'd4, 16'hF0F0, 16'h0FF0, 16'h0000, 1'b1);
        tick();
        chk("and_result", bus.outAluResult, 16'h00F0);
        chk("and_flags",  {13'd0, bus.flags}, 16'h0000);

        // SETC
        op(4'd11, 16'h0007, 16'h0000, 16'h0000, 1'b1);
        tick();
        chk("setc_result", bus.outAluResult, 16'h0007);
        chk("setc_flags",  {13'd0, bus.flags}, 16'h0002);

        idle();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
